// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - handshake and control bundle between the core sequencer and the datapath
interface core_sequencer_if #(parameter int RET_W = 16);
  logic             imem_req;
  logic             imem_ack;
  logic             ir_load;
  logic             dec_ldst;
  logic             dec_snl;
  logic             dec_write_en;
  logic             dec_set_flags;
  logic             dec_to_pc;
  logic             dec_halt;
  logic             dec_en;
  logic             dec_branch;
  logic [3:0]       dec_branch_cond;
  logic [3:0]       nzcv;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             pc_inc;
  logic             pc_load;
  logic             rf_we;
  logic             flags_we;
  logic             halted;
  logic [2:0]       state;
  logic [RET_W-1:0] retired;

  modport master (
    input  imem_ack, dec_ldst, dec_snl, dec_write_en, dec_set_flags, dec_to_pc,
           dec_halt, dec_en, dec_branch, dec_branch_cond, nzcv, dmem_ack,
    output imem_req, ir_load, dmem_req, dmem_we, pc_inc, pc_load, rf_we,
           flags_we, halted, state, retired
  );

  modport slave (
    output imem_ack, dec_ldst, dec_snl, dec_write_en, dec_set_flags, dec_to_pc,
           dec_halt, dec_en, dec_branch, dec_branch_cond, nzcv, dmem_ack,
    input  imem_req, ir_load, dmem_req, dmem_we, pc_inc, pc_load, rf_we,
           flags_we, halted, state, retired
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module core_sequencer #(
  parameter int RET_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  core_sequencer_if.master bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  logic [2:0]       stateQ, stateD;
  logic             ldstQ, snlQ, writeEnQ, setFlagsQ, toPcQ, enQ, branchQ;
  logic [3:0]       condQ, nzcvQ;
  logic [RET_W-1:0] retiredQ;
  logic             condMet, taken, retire;
  logic             flagN, flagZ, flagC, flagV;

  // Branch decision only ever sees the flags captured in DECODE.
  assign {flagN, flagZ, flagC, flagV} = nzcvQ;

  always_comb begin
    condMet = 1'b0;
    case (condQ)
      4'd0:    condMet = flagZ;
      4'd1:    condMet = !flagZ;
      4'd2:    condMet = flagC;
      4'd3:    condMet = !flagC;
      4'd4:    condMet = flagN;
      4'd5:    condMet = !flagN;
      4'd6:    condMet = flagV;
      4'd7:    condMet = !flagV;
      4'd8:    condMet = flagC & !flagZ;
      4'd9:    condMet = !flagC | flagZ;
      4'd10:   condMet = (flagN == flagV);
      4'd11:   condMet = (flagN != flagV);
      4'd12:   condMet = !flagZ & (flagN == flagV);
      4'd13:   condMet = flagZ | (flagN != flagV);
      4'd14:   condMet = 1'b1;
      default: condMet = 1'b0;
    endcase
  end

  assign taken = branchQ & condMet;

  always_comb begin
    stateD       = stateQ;
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.flags_we = 1'b0;
    bus.halted   = 1'b0;
    case (stateQ)
      IDLE: stateD = FETCH;
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_load = 1'b1;
          stateD      = DECODE;
        end
      end
      DECODE: stateD = bus.dec_halt ? HALT : EXEC;
      EXEC: begin
        stateD = FETCH;
        if (!enQ) begin
          bus.pc_inc = 1'b1;
        end else begin
          bus.flags_we = setFlagsQ;
          if (ldstQ) begin
            stateD = MEM;
          end else if (branchQ) begin
            bus.pc_load = taken;
            bus.pc_inc  = !taken;
          end else if (toPcQ) begin
            bus.pc_load = 1'b1;
          end else begin
            bus.rf_we  = writeEnQ;
            bus.pc_inc = 1'b1;
          end
        end
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = snlQ;
        if (bus.dmem_ack) begin
          if (snlQ) begin
            bus.pc_inc = 1'b1;
            stateD     = FETCH;
          end else begin
            stateD = WB;
          end
        end
      end
      WB: begin
        bus.rf_we  = 1'b1;
        bus.pc_inc = 1'b1;
        stateD     = FETCH;
      end
      HALT: bus.halted = 1'b1;
      default: stateD = IDLE;
    endcase
  end

  // Every completed instruction, no-ops included, returns to FETCH from one of these.
  assign retire = (stateD == FETCH) && ((stateQ == EXEC) || (stateQ == MEM) || (stateQ == WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      retiredQ  <= '0;
      ldstQ     <= 1'b0;
      snlQ      <= 1'b0;
      writeEnQ  <= 1'b0;
      setFlagsQ <= 1'b0;
      toPcQ     <= 1'b0;
      enQ       <= 1'b0;
      branchQ   <= 1'b0;
      condQ     <= '0;
      nzcvQ     <= '0;
    end else begin
      stateQ <= stateD;
      if (retire) begin
        retiredQ <= retiredQ + 1'b1;
      end
      if (stateQ == DECODE) begin
        ldstQ     <= bus.dec_ldst;
        snlQ      <= bus.dec_snl;
        writeEnQ  <= bus.dec_write_en;
        setFlagsQ <= bus.dec_set_flags;
        toPcQ     <= bus.dec_to_pc;
        enQ       <= bus.dec_en;
        branchQ   <= bus.dec_branch;
        condQ     <= bus.dec_branch_cond;
        nzcvQ     <= bus.nzcv;
      end
    end
  end

  assign bus.state   = stateQ;
  assign bus.retired = retiredQ;
endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer against an instruction-level model
module tb_core_sequencer;
  typedef struct packed {
    logic       ldst;
    logic       snl;
    logic       writeEn;
    logic       setFlags;
    logic       toPc;
    logic       halt;
    logic       en;
    logic       branch;
    logic [3:0] cond;
    logic [3:0] nzcv;
  } instr_t;

  logic clk;
  logic rst_n;
  int checks;
  int errors;
  logic [15:0] expRetired;
  logic [2:0] trace[$];

  core_sequencer_if #(.RET_W(16)) bus();
  core_sequencer #(.RET_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Conditions come in predicate/negation pairs, with 14/15 as always/never.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, p;
    {n, z, cc, v} = f;
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cc;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cc & !z;
      3'd5: p = (n == v);
      default: p = !z && (n == v);
    endcase
    return c[0] ? !p : p;
  endfunction

  task automatic drive_fields(input instr_t f);
    bus.dec_ldst        = f.ldst;
    bus.dec_snl         = f.snl;
    bus.dec_write_en    = f.writeEn;
    bus.dec_set_flags   = f.setFlags;
    bus.dec_to_pc       = f.toPc;
    bus.dec_halt        = f.halt;
    bus.dec_en          = f.en;
    bus.dec_branch      = f.branch;
    bus.dec_branch_cond = f.cond;
    bus.nzcv            = f.nzcv;
  endtask

  function automatic instr_t rand_instr();
    instr_t f;
    f = instr_t'($urandom);
    f.halt = 1'b0;
    return f;
  endfunction

  // Runs one instruction from its first FETCH cycle to its retiring cycle and checks it.
  task automatic exec_instr(input instr_t f, input int di, input int dd, input string name);
    int k, dmemCnt, cyc, eCyc, ePcInc, ePcLoad, eRf, eFl, eDReq, eDWe, eRet;
    int nPcInc, nPcLoad, nRf, nFl, nDReq, nDWe, nIr, nBoth;
    logic started, done;
    logic [2:0] eState;
    k = 0; dmemCnt = 0; started = 0; done = 0;
    nPcInc = 0; nPcLoad = 0; nRf = 0; nFl = 0; nDReq = 0; nDWe = 0; nIr = 0; nBoth = 0;
    eCyc = di + 3; ePcInc = 0; ePcLoad = 0; eRf = 0; eFl = 0; eDReq = 0; eDWe = 0; eRet = 1;
    eState = 3'd1;
    if (f.halt) begin
      eRet = 0;
      eState = 3'd6;
    end else if (!f.en) begin
      ePcInc = 1;
    end else begin
      eFl = f.setFlags;
      if (f.ldst) begin
        eDReq  = dd + 1;
        eDWe   = f.snl ? dd + 1 : 0;
        eCyc   = di + dd + (f.snl ? 4 : 5);
        eRf    = f.snl ? 0 : 1;
        ePcInc = 1;
      end else if (f.branch) begin
        ePcLoad = cond_ref(f.cond, f.nzcv);
        ePcInc  = !ePcLoad;
      end else if (f.toPc) begin
        ePcLoad = 1;
      end else begin
        eRf    = f.writeEn;
        ePcInc = 1;
      end
    end
    trace.delete();
    drive_fields(f);
    for (cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      if (!started && bus.imem_req) started = 1;
      if (started) begin
        bus.imem_ack = (k == di);
        bus.dmem_ack = bus.dmem_req && (dmemCnt == dd);
        if (k > di + 1) drive_fields(instr_t'($urandom));
        else drive_fields(f);
      end else begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
      end
      #1;
      if (started) begin
        trace.push_back(bus.state);
        nPcInc  += int'(bus.pc_inc);
        nPcLoad += int'(bus.pc_load);
        nRf     += int'(bus.rf_we);
        nFl     += int'(bus.flags_we);
        nDReq   += int'(bus.dmem_req);
        nDWe    += int'(bus.dmem_we);
        nIr     += int'(bus.ir_load);
        nBoth   += int'(bus.pc_inc && bus.pc_load);
        if (bus.dmem_req) dmemCnt++;
        if (bus.pc_inc || bus.pc_load || bus.halted) done = 1;
        k++;
      end
    end
    bus.imem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got no completion, required completion within 80 cycles", name);
    end
    checks++;
    if (k !== eCyc) begin errors++; $display("FAIL %s cycles: got %0d required %0d", name, k, eCyc); end
    checks++;
    if (nPcInc !== ePcInc) begin errors++; $display("FAIL %s pc_inc: got %0d required %0d", name, nPcInc, ePcInc); end
    checks++;
    if (nPcLoad !== ePcLoad) begin errors++; $display("FAIL %s pc_load: got %0d required %0d", name, nPcLoad, ePcLoad); end
    checks++;
    if (nRf !== eRf) begin errors++; $display("FAIL %s rf_we: got %0d required %0d", name, nRf, eRf); end
    checks++;
    if (nFl !== eFl) begin errors++; $display("FAIL %s flags_we: got %0d required %0d", name, nFl, eFl); end
    checks++;
    if (nDReq !== eDReq) begin errors++; $display("FAIL %s dmem_req: got %0d required %0d", name, nDReq, eDReq); end
    checks++;
    if (nDWe !== eDWe) begin errors++; $display("FAIL %s dmem_we: got %0d required %0d", name, nDWe, eDWe); end
    checks++;
    if (nIr !== 1 || nBoth !== 0) begin
      errors++;
      $display("FAIL %s ir_load/overlap: got %0d/%0d required 1/0", name, nIr, nBoth);
    end
    @(posedge clk);
    #1;
    expRetired = expRetired + 16'(eRet);
    checks++;
    if (bus.retired !== expRetired) begin errors++; $display("FAIL %s retired: got %0d required %0d", name, bus.retired, expRetired); end
    checks++;
    if (bus.state !== eState) begin errors++; $display("FAIL %s next state: got %0d required %0d", name, bus.state, eState); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    drive_fields('0);
    expRetired = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.pc_inc, bus.pc_load,
         bus.rf_we, bus.flags_we, bus.halted, bus.state, bus.retired} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got state=%0d retired=%0d imem_req=%0b required all zero",
               bus.state, bus.retired, bus.imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset idle: got %0d required 0", bus.state); end
  endtask

  task automatic test_alu();
    instr_t f;
    logic [2:0] expTrace[3];
    expTrace = '{3'd1, 3'd2, 3'd3};
    f = '0;
    f.en = 1; f.writeEn = 1; f.setFlags = 1;
    exec_instr(f, 0, 0, "alu_add");
    checks++;
    if (trace.size() !== 3) begin errors++; $display("FAIL alu trace length: got %0d required 3", trace.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (trace[i] !== expTrace[i]) begin
          errors++;
          $display("FAIL alu trace[%0d]: got %0d required %0d", i, trace[i], expTrace[i]);
        end
      end
    end
  endtask

  task automatic test_branch();
    instr_t f;
    f = '0;
    f.en = 1; f.branch = 1; f.cond = 4'd0;
    f.nzcv = 4'b0100;
    exec_instr(f, 0, 0, "branch_eq_taken");
    f.nzcv = 4'b0000;
    exec_instr(f, 1, 0, "branch_eq_not_taken");
    for (int i = 0; i < 4; i++) begin
      f.cond = 4'd15;
      f.nzcv = 4'($urandom);
      exec_instr(f, 0, 0, "branch_never");
    end
    for (int c = 0; c < 16; c++) begin
      f.cond = 4'(c);
      f.nzcv = 4'($urandom);
      exec_instr(f, 0, 0, "branch_cond_sweep");
    end
  endtask

  task automatic test_load_store();
    instr_t f;
    f = '0;
    f.en = 1; f.ldst = 1; f.snl = 0;
    exec_instr(f, 0, 3, "load_wait3");
    f.snl = 1;
    exec_instr(f, 0, 0, "store_fast");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      exec_instr(rand_instr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_noop_halt();
    instr_t f;
    logic [15:0] retSnap;
    int bad;
    f = '0;
    f.en = 0; f.setFlags = 1; f.writeEn = 1;
    exec_instr(f, 0, 0, "noop");
    f = '0;
    f.halt = 1; f.en = 1;
    exec_instr(f, 0, 0, "halt");
    retSnap = expRetired;
    bad = 0;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_fields(instr_t'($urandom));
      #1;
      if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.pc_inc || bus.pc_load) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL halt hold: got %0d bad cycles required 0", bad); end
    checks++;
    if (bus.retired !== retSnap) begin errors++; $display("FAIL halt retired: got %0d required %0d", bus.retired, retSnap); end
  endtask

  task automatic test_reset_mid_mem();
    instr_t f;
    logic inMem;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expRetired = '0;
    f = '0;
    f.en = 1; f.writeEn = 1;
    exec_instr(f, 0, 0, "pre_mem_alu");
    f = '0;
    f.en = 1; f.ldst = 1;
    drive_fields(f);
    bus.dmem_ack = 1'b0;
    inMem = 0;
    for (int i = 0; i < 20 && !inMem; i++) begin
      @(negedge clk);
      bus.imem_ack = bus.imem_req;
      #1;
      if (bus.dmem_req) inMem = 1;
    end
    bus.imem_ack = 1'b0;
    checks++;
    if (!inMem) begin errors++; $display("FAIL reset_mid_mem reach: got no dmem_req required dmem_req=1"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.state !== 3'd0 || bus.retired !== '0 || bus.pc_inc || bus.rf_we) begin
      errors++;
      $display("FAIL reset_mid_mem: got dmem_req=%0b state=%0d retired=%0d required 0/0/0",
               bus.dmem_req, bus.state, bus.retired);
    end
    expRetired = '0;
    @(negedge clk);
    rst_n = 1'b1;
    f = '0;
    f.en = 1; f.writeEn = 1; f.setFlags = 1;
    exec_instr(f, 0, 0, "post_reset_alu");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_random();
    test_noop_halt();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
